// File: rtl/divider_16.sv
// Sequential radix-2 restoring divider, signed Q2.13 in and out, 16-cycle fixed latency.
// Define DIV_ROUND_EN to round the quotient magnitude half-away-from-zero instead of truncating.
module divider_16 (
    input  logic        I_CLK,
    input  logic        I_RST_N,
    input  logic        I_VLD,
    input  logic [15:0] I_DIVIDEND,
    input  logic [15:0] I_DIVISOR,
    output logic        O_VLD,
    output logic        O_DIV_BUSY,
    output logic [15:0] O_QUOTIENT,
    output logic        O_DIV_ZERO
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [27:0] rem;
    logic [14:0] den;
    logic [14:0] quo;
    logic        sign;
    logic        dvd_neg;
    logic        zero_p;
    logic        ovf_p;

    logic [14:0] mag_a;
    logic [14:0] mag_b;
    logic [28:0] trial;
    logic        ge;
    logic [27:0] rem_nxt;
    logic [14:0] mag_fin;
    logic [15:0] result;

    // The most negative operand has no positive twin in 15 bits, so it clamps.
    function automatic logic [14:0] mag15(input logic [15:0] x);
        logic [15:0] n;
        n = ~x + 16'd1;
        if (x == 16'h8000) return 15'h7FFF;
        else if (x[15])    return n[14:0];
        else               return x[14:0];
    endfunction

    function automatic logic [15:0] apply_sign(input logic [14:0] m, input logic s);
        logic [15:0] w;
        w = {1'b0, m};
        return s ? (~w + 16'd1) : w;
    endfunction

    function automatic logic [15:0] saturate(input logic s);
        return s ? 16'h8000 : 16'h7FFF;
    endfunction

`ifdef DIV_ROUND_EN
    // The final remainder is below the divisor, so its low 15 bits hold it exactly.
    function automatic logic [14:0] round_mag(input logic [14:0] q, input logic [14:0] r,
                                              input logic [14:0] d);
        if ({r, 1'b0} >= {1'b0, d} && q != 15'h7FFF) return q + 15'd1;
        else                                         return q;
    endfunction
`endif

    always_comb begin
        mag_a   = mag15(I_DIVIDEND);
        mag_b   = mag15(I_DIVISOR);
        trial   = {14'd0, den} << cnt;
        ge      = ({1'b0, rem} >= trial);
        rem_nxt = ge ? (rem - trial[27:0]) : rem;
`ifdef DIV_ROUND_EN
        mag_fin = round_mag(quo, rem[14:0], den);
`else
        mag_fin = quo;
`endif
        if (zero_p)     result = saturate(dvd_neg);
        else if (ovf_p) result = saturate(sign);
        else            result = apply_sign(mag_fin, sign);
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rem        <= 28'd0;
            den        <= 15'd0;
            quo        <= 15'd0;
            sign       <= 1'b0;
            dvd_neg    <= 1'b0;
            zero_p     <= 1'b0;
            ovf_p      <= 1'b0;
            O_VLD      <= 1'b0;
            O_DIV_BUSY <= 1'b0;
            O_QUOTIENT <= 16'd0;
            O_DIV_ZERO <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    O_VLD      <= 1'b0;
                    O_QUOTIENT <= 16'd0;
                    O_DIV_ZERO <= 1'b0;
                    if (I_VLD) begin
                        sign       <= I_DIVIDEND[15] ^ I_DIVISOR[15];
                        dvd_neg    <= I_DIVIDEND[15];
                        den        <= mag_b;
                        rem        <= {mag_a, 13'd0};
                        quo        <= 15'd0;
                        cnt        <= 4'd14;
                        zero_p     <= (mag_b == 15'd0);
                        ovf_p      <= ({2'b00, mag_a} >= {mag_b, 2'b00});
                        O_DIV_BUSY <= 1'b1;
                        state      <= LOAD;
                    end
                end
                // LOAD carries the first iteration (bit 14) so latency stays at 16.
                LOAD: begin
                    rem      <= rem_nxt;
                    quo[cnt] <= ge;
                    cnt      <= cnt - 4'd1;
                    state    <= CALC;
                end
                CALC: begin
                    rem      <= rem_nxt;
                    quo[cnt] <= ge;
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE: begin
                    O_VLD      <= 1'b1;
                    O_DIV_BUSY <= 1'b0;
                    O_QUOTIENT <= result;
                    O_DIV_ZERO <= zero_p;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_16.sv
// Directed and randomized bench for divider_16 against an integer-arithmetic reference model.
module tb_divider_16;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        o_vld;
    logic        busy;
    logic [15:0] quotient;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    divider_16 dut (
        .I_CLK      (clk),
        .I_RST_N    (rst_n),
        .I_VLD      (vld),
        .I_DIVIDEND (dividend),
        .I_DIVISOR  (divisor),
        .O_VLD      (o_vld),
        .O_DIV_BUSY (busy),
        .O_QUOTIENT (quotient),
        .O_DIV_ZERO (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int mag(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // Returns {div_zero, quotient} from plain integer arithmetic on the real values.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        int ma, mb, q, r;
        bit s;
        ma = mag(a);
        mb = mag(b);
        s  = a[15] ^ b[15];
        if (mb == 0) return {1'b1, (a[15] ? 16'h8000 : 16'h7FFF)};
        if (ma >= 4 * mb) return {1'b0, (s ? 16'h8000 : 16'h7FFF)};
        q = (ma * 8192) / mb;
        r = (ma * 8192) % mb;
`ifdef DIV_ROUND_EN
        if (2 * r >= mb && q < 32767) q = q + 1;
`endif
        if (s) q = -q;
        return {1'b0, 16'(q)};
    endfunction

    // Called at posedge+1 with the divider expected idle (or in its result cycle).
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input bit noise);
        logic [16:0] exp;
        int n;
        int k;
        exp = model(a, b);
        k = 0;
        while (busy && k < 40) begin
            @(posedge clk); #1; k++;
        end
        check({tag, ".idle"}, busy, 0);
        dividend = a; divisor = b; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".clear"}, {o_vld, div_zero, quotient}, 0);
        n = 0;
        while (!o_vld && n < 40) begin
            if (noise && (n == 3 || n == 9)) begin
                vld = 1'b1; dividend = 16'($urandom); divisor = 16'($urandom);
            end else begin
                vld = 1'b0;
            end
            @(posedge clk); #1; n++;
        end
        vld = 1'b0;
        check({tag, ".latency"}, n, 16);
        check({tag, ".quot"}, quotient, exp[15:0]);
        check({tag, ".dz"}, div_zero, exp[16]);
        check({tag, ".busy_fall"}, busy, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        bit seen;
        rst_n = 1'b0; vld = 1'b0; dividend = 16'd0; divisor = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {o_vld, busy, div_zero, quotient}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("two_over_one", 16'h4000, 16'h2000, 0);
        check("two_over_one.value", quotient, 16'h4000);
        run("half", 16'h2000, 16'h4000, 0);
        check("half.value", quotient, 16'h1000);
        run("third", 16'h2000, 16'h6000, 0);
`ifdef DIV_ROUND_EN
        check("third.value", quotient, 16'h0AAB);
`else
        check("third.value", quotient, 16'h0AAA);
`endif
        run("neg_pos", 16'hE000, 16'h4000, 0);
        check("neg_pos.value", quotient, 16'hF000);
        run("neg_neg", 16'hE000, 16'hC000, 0);
        check("neg_neg.value", quotient, 16'h1000);
        run("zero_neg", 16'h0000, 16'hE000, 0);
        check("zero_neg.value", quotient, 16'h0000);
        run("sat_pos", 16'h6000, 16'h1000, 0);
        check("sat_pos.value", {div_zero, quotient}, 17'h07FFF);
        run("sat_neg", 16'hA000, 16'h1000, 0);
        check("sat_neg.value", quotient, 16'h8000);
        run("divzero_neg", 16'hE000, 16'h0000, 0);
        check("divzero_neg.value", {div_zero, quotient}, 17'h18000);
        run("divzero_pos", 16'h1234, 16'h0000, 0);
        run("min_operand", 16'h8000, 16'h7FFF, 0);

        // Requests while busy must be ignored.
        run("noise", 16'h3000, 16'hD000, 1);
        // A request during the result cycle is accepted immediately.
        run("b2b", 16'h2000, 16'h6000, 0);

        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 2 == 1) ra = 16'($signed(ra) >>> 3);
            if (i % 6 == 5) rb = 16'($signed(rb) >>> 10);
            run($sformatf("rand%0d", i), ra, rb, (i % 4 == 0));
        end

        // Asynchronous reset mid-calculation aborts the operation.
        dividend = 16'h4000; divisor = 16'h2000; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort.outputs", {o_vld, busy, div_zero, quotient}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            seen |= o_vld;
        end
        check("abort.no_vld", seen, 0);
        run("after_abort", 16'hC000, 16'h2000, 0);
        check("after_abort.value", quotient, 16'hC000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
